// File: rtl/riscv_pkg.sv
// Shared definitions for the single-cycle RISC-V core.
// Holds the datapath width, the fetch-stage state encoding and the PC step.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int PC_INC = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_adder.sv
// Combinational XLEN-wide adder; used for pc+4.
// The branch-target path can reuse it as well.
module pc_adder #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/pc_fetch.sv
// PC stage: boot sequencing, stall, redirect and misaligned-target trap.
// Also counts PC advances for debug.
module pc_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_valid,
  output logic            fault,
  output logic [XLEN-1:0] fault_pc,
  output logic [31:0]     adv_count
);

  import riscv_pkg::*;

  localparam logic [XLEN-1:0] INC = XLEN'(PC_INC);

  fetch_state_t state;
  logic         released;
  logic         misaligned;

  assign misaligned = |redirect_pc[1:0];

  pc_adder #(
    .XLEN(XLEN)
  ) u_pc_adder (
    .a  (pc),
    .b  (INC),
    .sum(pc_plus4)
  );

  // released marks the edge that ends the partial cycle in which rst
  // dropped; BOOT then spans one full cycle before RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      released    <= 1'b0;
      pc          <= RESET_PC;
      fetch_valid <= 1'b0;
      fault       <= 1'b0;
      fault_pc    <= '0;
      adv_count   <= '0;
    end else begin
      unique case (state)
        BOOT: begin
          released <= 1'b1;
          if (released) begin
            state       <= RUN;
            fetch_valid <= 1'b1;
          end
        end
        RUN: begin
          if (redirect && misaligned) begin
            state       <= FAULT;
            fault       <= 1'b1;
            fault_pc    <= redirect_pc;
            fetch_valid <= 1'b0;
          end else if (redirect) begin
            pc        <= redirect_pc;
            adv_count <= adv_count + 32'd1;
          end else if (!stall) begin
            pc        <= pc_plus4;
            adv_count <= adv_count + 32'd1;
          end
        end
        FAULT: begin
          fetch_valid <= 1'b0;
        end
        default: begin
          state       <= FAULT;
          fault       <= 1'b1;
          fetch_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed table, corner sequences,
// and randomized traffic against a cycle-level reference model.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] pc, pc_plus4, fault_pc, adv_count;
  logic        fetch_valid, fault;

  pc_fetch #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .fetch_valid(fetch_valid),
    .fault      (fault),
    .fault_pc   (fault_pc),
    .adv_count  (adv_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: edges seen since release decide boot progress
  logic [31:0] m_pc, m_cnt, m_fpc;
  bit          m_fault;
  int          m_edges;

  function automatic bit m_valid();
    return !m_fault && m_edges >= 2;
  endfunction

  function automatic void m_reset();
    m_pc    = 32'h0;
    m_cnt   = 32'h0;
    m_fpc   = 32'h0;
    m_fault = 1'b0;
    m_edges = 0;
  endfunction

  function automatic void m_edge(bit s, bit r, logic [31:0] t);
    if (m_valid()) begin
      if (r && t % 4 != 0) begin
        m_fault = 1'b1;
        m_fpc   = t;
      end else if (r) begin
        m_pc  = t;
        m_cnt = m_cnt + 1;
      end else if (!s) begin
        m_pc  = m_pc + 4;
        m_cnt = m_cnt + 1;
      end
    end
    if (m_edges < 2) m_edges++;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".pc_plus4"}, pc_plus4, m_pc + 32'd4);
    chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(m_valid()));
    chk({tag, ".fault"}, 32'(fault), 32'(m_fault));
    chk({tag, ".fault_pc"}, fault_pc, m_fpc);
    chk({tag, ".adv_count"}, adv_count, m_cnt);
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    m_edge(stall, redirect, redirect_pc);
    #1;
    check_model(tag);
  endtask

  // assert rst between edges, check the async effect, release after an edge
  task automatic do_reset(string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    m_reset();
    #1;
    check_model({tag, ".async"});
    @(posedge clk);
    #1 rst = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
  endtask

  typedef struct {
    bit          s;
    bit          r;
    logic [31:0] t;
    logic [31:0] e_pc;
    bit          e_valid;
    bit          e_fault;
    logic [31:0] e_fpc;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] rnd;
    m_reset();
    vecs = '{
      '{0, 0, 32'h0,   32'h0,   0, 0, 32'h0,   32'd0},
      '{0, 0, 32'h0,   32'h0,   1, 0, 32'h0,   32'd0},
      '{0, 0, 32'h0,   32'h4,   1, 0, 32'h0,   32'd1},
      '{0, 0, 32'h0,   32'h8,   1, 0, 32'h0,   32'd2},
      '{0, 0, 32'h0,   32'hC,   1, 0, 32'h0,   32'd3},
      '{0, 0, 32'h0,   32'h10,  1, 0, 32'h0,   32'd4},
      '{1, 0, 32'h0,   32'h10,  1, 0, 32'h0,   32'd4},
      '{1, 0, 32'h0,   32'h10,  1, 0, 32'h0,   32'd4},
      '{1, 0, 32'h0,   32'h10,  1, 0, 32'h0,   32'd4},
      '{0, 0, 32'h0,   32'h14,  1, 0, 32'h0,   32'd5},
      '{0, 0, 32'h0,   32'h18,  1, 0, 32'h0,   32'd6},
      '{0, 0, 32'h0,   32'h1C,  1, 0, 32'h0,   32'd7},
      '{0, 0, 32'h0,   32'h20,  1, 0, 32'h0,   32'd8},
      '{1, 1, 32'h100, 32'h100, 1, 0, 32'h0,   32'd9},
      '{0, 1, 32'h102, 32'h100, 0, 1, 32'h102, 32'd9},
      '{0, 1, 32'h200, 32'h100, 0, 1, 32'h102, 32'd9},
      '{1, 0, 32'h0,   32'h100, 0, 1, 32'h102, 32'd9},
      '{0, 0, 32'h0,   32'h100, 0, 1, 32'h102, 32'd9}
    };

    // reset state, checked while rst is held
    #2;
    check_model("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) begin
      stall = vecs[i].s;
      redirect = vecs[i].r;
      redirect_pc = vecs[i].t;
      tick($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.pc", i), pc, vecs[i].e_pc);
      chk($sformatf("vec%0d.valid", i), 32'(fetch_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d.fault", i), 32'(fault), 32'(vecs[i].e_fault));
      chk($sformatf("vec%0d.fault_pc", i), fault_pc, vecs[i].e_fpc);
      chk($sformatf("vec%0d.count", i), adv_count, vecs[i].e_cnt);
    end

    // PC wrap at the top of the address space
    do_reset("wrap_rst");
    tick("wrap_boot0");
    tick("wrap_boot1");
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick("wrap_redir");
    chk("wrap_plus4_top", pc_plus4, 32'h0);
    redirect = 1'b0;
    tick("wrap_run");
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_plus4", pc_plus4, 32'h4);

    // async reset mid-cycle at pc=0x40, then boot repeats
    redirect = 1'b1;
    redirect_pc = 32'h3C;
    tick("mid_redir");
    redirect = 1'b0;
    tick("mid_run");
    chk("mid_pc40", pc, 32'h40);
    do_reset("mid_rst");
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_cnt", adv_count, 32'h0);
    tick("reboot0");
    chk("reboot0_valid", 32'(fetch_valid), 32'd0);
    tick("reboot1");
    chk("reboot1_valid", 32'(fetch_valid), 32'd1);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 199) == 0 || (m_fault && $urandom_range(0, 9) == 0)) begin
        do_reset("rnd_rst");
      end
      stall = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 4) == 0);
      rnd = $urandom;
      if ($urandom_range(0, 39) != 0) rnd[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) rnd[31:8] = 24'hFFFFFF;
      redirect_pc = rnd;
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
